up_counter_ctrl: RTL and testbench

Parameterised up-counter with programmable terminal value, free-running (wrap) or one-shot mode, synchronous load, and start/stop control. It is the counting-up counterpart to the team's 4-bit down counter. It serves as a period/event timer in the same designs: other logic starts it, it counts enabled cycles up to `limit`, and it flags each terminal count.

---
 rtl/up_counter_pkg.sv | 13 +
 rtl/up_counter_fsm.sv | 94 +++++++++
 rtl/up_counter_ctrl.sv | 73 +++++++
 tb/tb_up_counter_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/up_counter_pkg.sv
// Shared types and defaults for the up-counter timer block.
// Holds the control state encoding and the default wrap-counter width.
package up_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int WRAP_W_DEFAULT = 8;

endpackage

// File: rtl/up_counter_fsm.sv
// Control FSM for up_counter_ctrl: owns IDLE/RUN/DONE, registered busy/done.
// Latency: busy/done update one edge after the qualifying input; strobes are same-cycle decodes, no backpressure.
module up_counter_fsm
    import up_counter_pkg::*;
(
    input  logic clk,
    input  logic rest,
    input  logic start,
    input  logic stop,
    input  logic en,
    input  logic load,
    input  logic one_shot,
    input  logic at_limit,
    output logic busy,
    output logic done,
    output logic clr,
    output logic ld,
    output logic inc,
    output logic term
);

    state_t state;

    // Datapath strobes; in RUN they follow stop > start > load > en.
    always_comb begin
        clr  = 1'b0;
        ld   = 1'b0;
        inc  = 1'b0;
        term = 1'b0;
        case (state)
            IDLE: clr = start;
            RUN: begin
                if (!stop) begin
                    if (start) begin
                        clr = 1'b1;
                    end else if (load) begin
                        ld = 1'b1;
                    end else if (en) begin
                        if (at_limit) begin
                            term = 1'b1;
                        end else begin
                            inc = 1'b1;
                        end
                    end
                end
            end
            DONE: clr = start & ~stop;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rest) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (term && one_shot) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    if (stop) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end else if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/up_counter_ctrl.sv
// Up-counter timer with programmable limit, wrap/one-shot, load and start/stop; flags each terminal count.
// Latency: all outputs registered, one edge from inputs; no backpressure, en qualifies each increment.
module up_counter_ctrl
    import up_counter_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int WRAP_W = WRAP_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rest,
    input  logic              start,
    input  logic              stop,
    input  logic              en,
    input  logic              one_shot,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic [WIDTH-1:0]  limit,
    output logic [WIDTH-1:0]  cnt,
    output logic              tc,
    output logic              busy,
    output logic              done,
    output logic [WRAP_W-1:0] wraps
);

    logic clr;
    logic ld;
    logic inc;
    logic term;

    up_counter_fsm u_fsm (
        .clk      (clk),
        .rest     (rest),
        .start    (start),
        .stop     (stop),
        .en       (en),
        .load     (load),
        .one_shot (one_shot),
        .at_limit (cnt == limit),
        .busy     (busy),
        .done     (done),
        .clr      (clr),
        .ld       (ld),
        .inc      (inc),
        .term     (term)
    );

    // A count above limit rolls through 2^WIDTH-1 to 0 via plain increment, so no tc there.
    always_ff @(posedge clk) begin
        if (rest) begin
            cnt   <= '0;
            wraps <= '0;
            tc    <= 1'b0;
        end else begin
            tc <= term;
            if (clr) begin
                cnt   <= '0;
                wraps <= '0;
            end else if (ld) begin
                cnt <= load_val;
            end else if (term) begin
                if (!one_shot) begin
                    cnt <= '0;
                    if (wraps != {WRAP_W{1'b1}}) begin
                        wraps <= wraps + WRAP_W'(1);
                    end
                end
            end else if (inc) begin
                cnt <= cnt + WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_up_counter_ctrl.sv
// Randomized plus directed bench for up_counter_ctrl against an integer reference model.
module tb_up_counter_ctrl;

    logic       clk = 1'b0;
    logic       rest, start, stop, en, one_shot, load;
    logic [3:0] load_val, limit;
    logic [3:0] cnt;
    logic       tc, busy, done;
    logic [7:0] wraps;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Reference model: 0 = idle, 1 = running, 2 = finished
    int m_st = 0, m_cnt = 0, m_wr = 0, m_tc = 0;

    always #5 clk = ~clk;

    up_counter_ctrl #(.WIDTH(4), .WRAP_W(8)) dut (
        .clk      (clk),
        .rest     (rest),
        .start    (start),
        .stop     (stop),
        .en       (en),
        .one_shot (one_shot),
        .load     (load),
        .load_val (load_val),
        .limit    (limit),
        .cnt      (cnt),
        .tc       (tc),
        .busy     (busy),
        .done     (done),
        .wraps    (wraps)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_edge(input int r, s, p, e, os, l, lv, lim);
        if (r != 0) begin
            m_st = 0; m_cnt = 0; m_wr = 0; m_tc = 0;
            return;
        end
        m_tc = 0;
        if (m_st == 0) begin
            if (s != 0) begin m_st = 1; m_cnt = 0; m_wr = 0; end
        end else if (m_st == 1) begin
            if (p != 0) m_st = 0;
            else if (s != 0) begin m_cnt = 0; m_wr = 0; end
            else if (l != 0) m_cnt = lv;
            else if (e != 0) begin
                if (m_cnt == lim) begin
                    m_tc = 1;
                    if (os != 0) m_st = 2;
                    else begin
                        m_cnt = 0;
                        m_wr = (m_wr < 255) ? m_wr + 1 : 255;
                    end
                end else begin
                    m_cnt = (m_cnt + 1) % 16;
                end
            end
        end else begin
            if (p != 0) m_st = 0;
            else if (s != 0) begin m_st = 1; m_cnt = 0; m_wr = 0; end
        end
    endtask

    // One clock: drive inputs, advance the model, then compare every output after the edge.
    task automatic step(input int r, s, p, e, os, l, lv, lim);
        rest = r[0]; start = s[0]; stop = p[0]; en = e[0];
        one_shot = os[0]; load = l[0]; load_val = lv[3:0]; limit = lim[3:0];
        model_edge(r, s, p, e, os, l, lv, lim);
        @(posedge clk);
        #1;
        cyc++;
        chk("cnt",   int'(cnt),   m_cnt);
        chk("tc",    int'(tc),    m_tc);
        chk("busy",  int'(busy),  (m_st == 1) ? 1 : 0);
        chk("done",  int'(done),  (m_st == 2) ? 1 : 0);
        chk("wraps", int'(wraps), m_wr);
    endtask

    initial begin
        int pat[4];
        rest = 1'b1; start = 1'b0; stop = 1'b0; en = 1'b0;
        one_shot = 1'b0; load = 1'b0; load_val = '0; limit = '0;

        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_busy_lit", int'(busy), 0);
        chk("reset_cnt_lit", int'(cnt), 0);

        // Reset mid-count at cnt = 7
        step(0, 1, 0, 0, 0, 0, 0, 15);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 0, 0, 0, 15);
        chk("midcount_cnt_lit", int'(cnt), 7);
        step(1, 0, 0, 1, 0, 0, 0, 15);
        chk("rest_cnt_lit", int'(cnt), 0);
        chk("rest_busy_lit", int'(busy), 0);
        step(0, 0, 0, 1, 0, 0, 0, 15);
        chk("idle_hold_cnt_lit", int'(cnt), 0);

        // Wrap mode, limit 5, 14 enabled cycles
        step(0, 1, 0, 0, 0, 0, 0, 5);
        for (int i = 0; i < 14; i++) begin
            step(0, 0, 0, 1, 0, 0, 0, 5);
            if (i == 5) chk("wrap_tc_lit", int'(tc), 1);
            if (i == 6) chk("wrap_tc_low_lit", int'(tc), 0);
        end
        chk("wrap_wraps_lit", int'(wraps), 2);
        chk("wrap_cnt_lit", int'(cnt), 2);

        // One-shot, limit 3
        step(0, 1, 0, 0, 1, 0, 0, 3);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, 0, 0, 3);
        chk("oneshot_tc_lit", int'(tc), 1);
        chk("oneshot_done_lit", int'(done), 1);
        chk("oneshot_cnt_lit", int'(cnt), 3);
        step(0, 0, 0, 1, 1, 1, 9, 3);
        chk("done_ignore_cnt_lit", int'(cnt), 3);
        chk("done_ignore_tc_lit", int'(tc), 0);
        step(0, 1, 0, 0, 1, 0, 0, 3);
        chk("restart_busy_lit", int'(busy), 1);

        // Load above limit: 14,15,0 silently, then up to 4 and wrap
        step(0, 1, 0, 0, 0, 0, 0, 4);
        step(0, 0, 0, 0, 0, 1, 14, 4);
        chk("load_cnt_lit", int'(cnt), 14);
        step(0, 0, 0, 1, 0, 0, 0, 4);
        step(0, 0, 0, 1, 0, 0, 0, 4);
        chk("silent_roll_cnt_lit", int'(cnt), 0);
        chk("silent_roll_tc_lit", int'(tc), 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 0, 0, 4);
        chk("load_wrap_tc_lit", int'(tc), 1);
        chk("load_wrap_wraps_lit", int'(wraps), 1);

        // Priority checks
        step(0, 0, 0, 0, 0, 1, 9, 15);
        step(0, 1, 1, 1, 0, 1, 6, 15);
        chk("prio_stop_cnt_lit", int'(cnt), 9);
        chk("prio_stop_busy_lit", int'(busy), 0);
        step(0, 1, 0, 0, 0, 0, 0, 15);
        step(0, 0, 0, 1, 0, 0, 0, 15);
        step(0, 1, 0, 1, 0, 1, 6, 15);
        chk("prio_start_cnt_lit", int'(cnt), 0);

        // limit 0 wrap mode, en 1,1,0,1
        pat = '{1, 1, 0, 1};
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, pat[i], 0, 0, 0, 0);
            chk("lim0_tc_lit", int'(tc), pat[i]);
        end
        chk("lim0_wraps_lit", int'(wraps), 3);

        // Randomized traffic
        begin
            int lim = 6;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 15) == 0) lim = $urandom_range(0, 15);
                step(($urandom_range(0, 99) == 0) ? 1 : 0,
                     ($urandom_range(0, 24) == 0) ? 1 : 0,
                     ($urandom_range(0, 29) == 0) ? 1 : 0,
                     ($urandom_range(0, 3) != 0) ? 1 : 0,
                     ($urandom_range(0, 3) == 0) ? 1 : 0,
                     ($urandom_range(0, 11) == 0) ? 1 : 0,
                     $urandom_range(0, 15),
                     lim);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
